// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO-side signal bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      full;
    logic                      we;
    logic [DATA_W-1:0]         data_in;
    logic                      gnt_valid;
    logic [ID_W-1:0]           gnt_id;

    // master: the arbiter; slave: producers plus the FIFO write port
    modport master (
        input  req_valid, req_data, full,
        output req_ready, we, data_in, gnt_valid, gnt_id
    );

    modport slave (
        output req_valid, req_data, full,
        input  req_ready, we, data_in, gnt_valid, gnt_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port; burst mode via FIFO_ARB_BURST_EN
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.master  bus
);
    localparam int ID_W = $clog2(NUM_REQ);
`ifdef FIFO_ARB_BURST_EN
    localparam int BURST_LIM = MAX_BURST;
`else
    // single-word grants; MAX_BURST has no effect in this build
    localparam int BURST_LIM = 1 + 0 * MAX_BURST;
`endif

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   gnt_id, gnt_id_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [3:0]        beat_cnt, beat_cnt_nxt;
    logic [DATA_W-1:0] last_word, last_word_nxt;
    logic [DATA_W-1:0] words [NUM_REQ];
    logic [ID_W-1:0]   pick_id, cand;
    logic              pick_found;
    logic              beat;
    logic              burst_done;
    int                cand_int;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign words[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // first valid requester after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand_int   = 0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_int = (int'(rr_ptr) + k) % NUM_REQ;
            cand     = ID_W'(cand_int);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt_id_nxt    = gnt_id;
        rr_ptr_nxt    = rr_ptr;
        beat_cnt_nxt  = beat_cnt;
        last_word_nxt = last_word;
        beat          = 1'b0;
        burst_done    = 1'b0;
        bus.req_ready = '0;
        bus.we        = 1'b0;
        bus.data_in   = last_word;
        bus.gnt_valid = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_id_nxt   = pick_id;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                bus.gnt_valid         = 1'b1;
                bus.req_ready[gnt_id] = !bus.full;
                beat                  = bus.req_valid[gnt_id] & !bus.full;
                burst_done            = beat && (({1'b0, beat_cnt} + 5'd1) == 5'(BURST_LIM));
                bus.we                = beat;
                if (beat) begin
                    bus.data_in   = words[gnt_id];
                    last_word_nxt = words[gnt_id];
                    beat_cnt_nxt  = beat_cnt + 4'd1;
                end
                // a dropped valid ends the grant even while the FIFO is full
                if (!bus.req_valid[gnt_id] || burst_done) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = gnt_id;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_id    <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            last_word <= '0;
        end else begin
            state     <= state_nxt;
            gnt_id    <= gnt_id_nxt;
            beat_cnt  <= beat_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            last_word <= last_word_nxt;
        end
    end

    assign bus.gnt_id = gnt_id;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a grant-level reference model
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int LIMIT = MAX_BURST;
`else
    localparam int LIMIT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model: owner = -1 when nobody holds the port
    int m_owner = -1;
    int m_taken = 0;
    int m_last  = NUM_REQ - 1;
    logic [DATA_W-1:0] m_word = '0;

    // producers: requester i offers base[i] + number of words already accepted
    logic [DATA_W-1:0] base [NUM_REQ];
    int seq [NUM_REQ];

    logic [38:0] exp_snap, obs_snap;
    logic        obs_gv, obs_we, prev_gv;
    logic [1:0]  obs_id;
    logic [3:0]  obs_rdy;
    logic [DATA_W-1:0] wr_q [$];
    int gnt_q [$];
    int beat_q [$];

    task automatic run_cycle(input logic [3:0] v, input logic f, input logic r);
        logic              e_gv, e_we;
        logic [1:0]        e_id;
        logic [3:0]        e_rdy;
        logic [DATA_W-1:0] e_data;
        int                cand;
        logic              found;
        @(negedge clk);
        reset         = r;
        bus.full      = f;
        bus.req_valid = v;
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_data[i*DATA_W +: DATA_W] = base[i] + DATA_W'(seq[i]);
        #1;
        e_gv   = (m_owner >= 0);
        e_id   = e_gv ? m_owner[1:0] : 2'd0;
        e_rdy  = (e_gv && !f) ? (4'b0001 << m_owner[1:0]) : 4'b0000;
        e_we   = e_gv && v[m_owner[1:0]] && !f;
        e_data = e_we ? base[m_owner[1:0]] + DATA_W'(seq[m_owner[1:0]]) : m_word;
        exp_snap = {e_gv, e_id, e_rdy, e_we, e_data};
        obs_gv  = bus.gnt_valid;
        obs_id  = bus.gnt_id;
        obs_rdy = bus.req_ready;
        obs_we  = bus.we;
        obs_snap = {obs_gv, obs_gv ? obs_id : 2'd0, obs_rdy, obs_we, bus.data_in};
        if (obs_gv && !prev_gv) begin
            gnt_q.push_back(int'(obs_id));
            beat_q.push_back(0);
        end
        if (obs_we) begin
            wr_q.push_back(bus.data_in);
            if (beat_q.size() > 0) beat_q[beat_q.size()-1]++;
        end
        prev_gv = obs_gv;
        @(posedge clk);
        if (r) begin
            m_owner = -1; m_taken = 0; m_last = NUM_REQ - 1; m_word = '0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = (m_last + k) % NUM_REQ;
                if (!found && v[cand[1:0]]) begin
                    found = 1'b1; m_owner = cand; m_taken = 0;
                end
            end
        end else if (!v[m_owner[1:0]]) begin
            m_last = m_owner; m_owner = -1;
        end else if (e_we) begin
            m_word = e_data;
            seq[m_owner[1:0]]++;
            m_taken++;
            if (m_taken == LIMIT) begin
                m_last = m_owner; m_owner = -1;
            end
        end
        cyc++;
    endtask

    task automatic fresh_start(input logic [DATA_W-1:0] b0);
        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i]  = 0;
            base[i] = b0 + DATA_W'(i << 16);
        end
        run_cycle(4'b0000, 1'b0, 1'b1);
        wr_q.delete(); gnt_q.delete(); beat_q.delete();
    endtask

    task automatic test_reset();
        prev_gv = 1'b0;
        bus.req_data = '0;
        fresh_start(32'h0);
        run_cycle(4'b0000, 1'b0, 1'b1);
        #1;
        checks++; if (bus.gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_gnt_valid got=%b want=0", bus.gnt_valid); end
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", bus.we); end
        checks++; if (bus.data_in !== 32'h0) begin failures++; $display("FAIL reset_data_in got=%h want=0", bus.data_in); end
    endtask

    task automatic test_single_requester();
        int first_we = -1;
        int n_exp = 0;
        fresh_start(32'hA0);
        for (int c = 0; c < 12; c++) begin
            run_cycle(4'b0001, 1'b0, 1'b0);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
            if (obs_we && first_we < 0) first_we = c;
            if (c >= 1 && ((c - 1) % (LIMIT + 1)) < LIMIT) n_exp++;
        end
        checks++; if (first_we !== 1) begin failures++; $display("FAIL single_first_write got=%0d want=1", first_we); end
        checks++; if (wr_q.size() !== n_exp) begin failures++; $display("FAIL single_write_count got=%0d want=%0d", wr_q.size(), n_exp); end
        foreach (wr_q[k]) begin
            checks++; if (wr_q[k] !== 32'hA0 + DATA_W'(k)) begin failures++; $display("FAIL single_word%0d got=%h want=%h", k, wr_q[k], 32'hA0 + k); end
        end
        repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        fresh_start(32'h1000_0000);
        for (int c = 0; c < 48; c++) begin
            run_cycle(4'b1111, 1'b0, 1'b0);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL rr cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
        end
        checks++; if (gnt_q.size() < 8) begin failures++; $display("FAIL rr_grant_count got=%0d want>=8", gnt_q.size()); end
        for (int k = 0; k < 8 && k < gnt_q.size(); k++) begin
            checks++; if (gnt_q[k] !== k % NUM_REQ) begin failures++; $display("FAIL rr_order%0d got=%0d want=%0d", k, gnt_q[k], k % NUM_REQ); end
        end
        repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_burst_pair();
        fresh_start(32'h2000_0000);
        for (int c = 0; c < 30; c++) begin
            run_cycle(4'b0101, 1'b0, 1'b0);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL pair cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < gnt_q.size()) begin
                checks++; if (gnt_q[k] !== (k % 2) * 2) begin failures++; $display("FAIL pair_order%0d got=%0d want=%0d", k, gnt_q[k], (k % 2) * 2); end
                checks++; if (beat_q[k] !== LIMIT) begin failures++; $display("FAIL pair_beats%0d got=%0d want=%0d", k, beat_q[k], LIMIT); end
            end else begin
                checks++; failures++; $display("FAIL pair_grant_missing%0d got=%0d want>%0d", k, gnt_q.size(), k);
            end
        end
        repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_full_stall();
        logic f;
        fresh_start(32'hA0);
        for (int c = 0; c < 16; c++) begin
            f = (c >= 3 && c < 8);
            run_cycle(4'b0001, f, 1'b0);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
            if (f) begin
                checks++; if (obs_we !== 1'b0 || obs_rdy !== 4'b0) begin failures++; $display("FAIL stall_quiet cyc=%0d got=we%b/rdy%b want=we0/rdy0000", cyc, obs_we, obs_rdy); end
            end
        end
        checks++; if (wr_q.size() !== seq[0]) begin failures++; $display("FAIL stall_count got=%0d want=%0d", wr_q.size(), seq[0]); end
        foreach (wr_q[k]) begin
            checks++; if (wr_q[k] !== 32'hA0 + DATA_W'(k)) begin failures++; $display("FAIL stall_word%0d got=%h want=%h", k, wr_q[k], 32'hA0 + k); end
        end
        repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int budget = 40;
        fresh_start(32'h3000_0000);
        do begin
            run_cycle(4'b1111, 1'b0, 1'b0);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL rmid cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
            budget--;
        end while (!(obs_gv && obs_id == 2'd2) && budget > 0);
        if (budget == 0) begin
            checks++; failures++; $display("FAIL rmid_timeout got=no_grant2 want=grant2");
        end
        run_cycle(4'b1111, 1'b0, 1'b1);
        #1;
        checks++; if (bus.gnt_valid !== 1'b0 || bus.we !== 1'b0) begin failures++; $display("FAIL rmid_drop got=gv%b/we%b want=gv0/we0", bus.gnt_valid, bus.we); end
        run_cycle(4'b1111, 1'b0, 1'b0);
        run_cycle(4'b1111, 1'b0, 1'b0);
        checks++; if (!(obs_gv === 1'b1 && obs_id === 2'd0)) begin failures++; $display("FAIL rmid_first got=gv%b/id%0d want=gv1/id0", obs_gv, obs_id); end
        repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_valid_drop();
        fresh_start(32'h4000_0000);
        for (int c = 0; c < 12; c++) begin
            run_cycle((seq[0] >= 1) ? 4'b0010 : 4'b0011, 1'b0, 1'b0);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL drop cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
        end
        checks++; if (gnt_q.size() < 2 || gnt_q[0] !== 0 || gnt_q[1] !== 1) begin failures++; $display("FAIL drop_order got=n%0d want=0,1", gnt_q.size()); end
        checks++; if (beat_q.size() < 1 || beat_q[0] !== 1) begin failures++; $display("FAIL drop_beats got=n%0d want=1", beat_q.size()); end
        repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic f, r;
        fresh_start(32'($urandom));
        for (int i = 0; i < NUM_REQ; i++) base[i] = 32'($urandom);
        for (int c = 0; c < 600; c++) begin
            v = 4'($urandom);
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 99) == 0);
            run_cycle(v, f, r);
            checks++; if (obs_snap !== exp_snap) begin failures++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_snap, exp_snap); end
            checks++; if ($countones(obs_rdy) > 1 || (obs_we && f)) begin failures++; $display("FAIL random_invariant cyc=%0d got=rdy%b/we%b/full%b want=onehot0,no_we_on_full", cyc, obs_rdy, obs_we, f); end
        end
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_burst_pair();
        test_full_stall();
        test_reset_mid();
        test_valid_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
